complex_multiplier_stream: RTL and testbench
============================================

// Module: complex_multiplier_stream
// PURPOSE
//  Pipelined signed complex multiplier with valid/ready flow control and per-sample conjugate mode.
//  Computes c = a*b, or c = a*conj(b) when in_conj=1.
//  Full-precision result is arithmetic-shifted right by SHIFT and reduced to OUT_WIDTH bits.
//  Generalised successor of complex_multiplier, for DSP datapaths (mixers, correlators) that need backpressure.
// PARAMETERS
//  A_WIDTH    16                     width of a_re/a_im, signed two's complement
//  B_WIDTH    16                     width of b_re/b_im, signed two's complement
//  OUT_WIDTH  A_WIDTH+B_WIDTH+1      width of c_re/c_im, signed
//  SHIFT      0                      right-shift applied to full product; SHIFT+OUT_WIDTH <= A_WIDTH+B_WIDTH+1
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          input sample valid
//  in_ready   out  1          block accepts a sample this cycle
//  in_conj    in   1          1: multiply by conj(b); sampled with the data
//  a_re,a_im  in   A_WIDTH    operand a
//  b_re,b_im  in   B_WIDTH    operand b
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts result
//  c_re,c_im  out  OUT_WIDTH  result
//  ovf        out  1          result of this beat was clipped (saturation build only)
// BEHAVIOUR
//  - Reset: out_valid=0, c_re=c_im=0, ovf=0, all internal valid bits cleared; in_ready=1 the cycle after rst deasserts.
//  - Reset mid-operation: every in-flight sample is discarded and nothing is output for it.
//  - Global stall: ce = !out_valid || out_ready; in_ready = ce (combinational).
//    Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
//  - All three stages advance only when ce=1; valid bits shift with the data; bubbles propagate as valid=0.
//  - S1: register operands; bim = in_conj ? -b_im : b_im, computed in B_WIDTH+1 bits (-(-2^(B-1)) is exact).
//  - S2: register the four products ar*br, ai*bim, ar*bim, ai*br at full signed width.
//  - S3: re = ar*br - ai*bim; im = ar*bim + ai*br; full width F = A_WIDTH+B_WIDTH+1 is exact for every input.
//    Then floor shift (re>>>SHIFT) and register to c_*.
//  - Latency: 3 cycles from accepted input to out_valid when out_ready stays high; throughput 1/cycle.
//  - Output stays stable while out_valid && !out_ready. No sample is dropped or duplicated.
//  - Reduction to OUT_WIDTH: without the macro, keep the OUT_WIDTH LSBs of the shifted value (wrap).
// CONFIGURATION
//  CMPLX_MULT_SAT_EN defined:
//   - Each shifted component is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//   - ovf=1 on the output beat if either component was clamped; otherwise ovf=0.
//   - ovf follows out_valid timing and is 0 when out_valid=0.
//  CMPLX_MULT_SAT_EN undefined: wrap as above; ovf tied to 0.
//  When OUT_WIDTH+SHIFT == F, saturation never triggers.
// TESTING  (A_WIDTH=10, B_WIDTH=15, F=26)
//  1 OUT_WIDTH=26, SHIFT=0: a=3+4j, b=5-2j, conj=0 -> c=23+14j after exactly 3 cycles.
//  2 Same a, b, conj=1 -> c=7+26j.
//  3 a=-512-512j, b=-16384-16384j -> c=0+16777216j (full-width corner, no overflow).
//  4 Case 3 with OUT_WIDTH=16, SHIFT=0:
//     SAT_EN -> c=0+32767j, ovf=1; no macro -> c=0+0j, ovf=0.
//  5 Stream 10 random samples, out_ready=0 for 5 cycles mid-stream:
//     in_ready drops while out_valid; c_* held stable; all 10 results match the model, in order.
//  6 rst=1 for 1 cycle with 2 samples in flight:
//     next cycle out_valid=0, c=0; those samples never appear; the next input returns after 3 cycles.

Source files
------------

// File: rtl/complex_multiplier_stream.sv
// complex_multiplier_stream: 3-stage signed complex multiply c = a*b or a*conj(b) with valid/ready; define CMPLX_MULT_SAT_EN for saturation + ovf
module complex_multiplier_stream #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = A_WIDTH + B_WIDTH + 1,
  parameter int SHIFT     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_conj,
  input  logic signed [A_WIDTH-1:0]   a_re,
  input  logic signed [A_WIDTH-1:0]   a_im,
  input  logic signed [B_WIDTH-1:0]   b_re,
  input  logic signed [B_WIDTH-1:0]   b_im,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] c_re,
  output logic signed [OUT_WIDTH-1:0] c_im,
  output logic                        ovf
);
  localparam int F = A_WIDTH + B_WIDTH + 1;
  logic w_ce;
  logic signed [B_WIDTH:0] w_bi_ext, w_bim;
  logic r_s1_v, r_s2_v;
  logic signed [A_WIDTH-1:0] r_ar, r_ai;
  logic signed [B_WIDTH-1:0] r_br;
  logic signed [B_WIDTH:0] r_bim;
  logic signed [F-1:0] r_p_rr, r_p_ib, r_p_rb, r_p_ir;
  logic signed [F-1:0] w_re, w_im, w_re_sh, w_im_sh;
  logic signed [OUT_WIDTH-1:0] w_c_re, w_c_im;
  logic w_ovf;
  assign w_ce     = !out_valid || out_ready;
  assign in_ready = w_ce;
  // one extra bit so negating the most negative b_im stays exact
  assign w_bi_ext = {b_im[B_WIDTH-1], b_im};
  assign w_bim    = in_conj ? -w_bi_ext : w_bi_ext;
  // F bits hold every sum/difference of two products without loss
  assign w_re     = r_p_rr - r_p_ib;
  assign w_im     = r_p_rb + r_p_ir;
  assign w_re_sh  = w_re >>> SHIFT;
  assign w_im_sh  = w_im >>> SHIFT;
`ifdef CMPLX_MULT_SAT_EN
  logic [F-OUT_WIDTH:0] w_re_top, w_im_top;
  logic w_re_ok, w_im_ok;
  assign w_re_top = w_re_sh[F-1:OUT_WIDTH-1];
  assign w_im_top = w_im_sh[F-1:OUT_WIDTH-1];
  assign w_re_ok  = (&w_re_top) || !(|w_re_top);
  assign w_im_ok  = (&w_im_top) || !(|w_im_top);
  assign w_c_re   = w_re_ok ? w_re_sh[OUT_WIDTH-1:0] : {w_re_sh[F-1], {(OUT_WIDTH-1){~w_re_sh[F-1]}}};
  assign w_c_im   = w_im_ok ? w_im_sh[OUT_WIDTH-1:0] : {w_im_sh[F-1], {(OUT_WIDTH-1){~w_im_sh[F-1]}}};
  assign w_ovf    = !(w_re_ok && w_im_ok);
`else
  assign w_c_re   = w_re_sh[OUT_WIDTH-1:0];
  assign w_c_im   = w_im_sh[OUT_WIDTH-1:0];
  assign w_ovf    = 1'b0;
`endif
  // datapath registers: operands then products, frozen together on stall
  always_ff @(posedge clk) begin
    if (w_ce) begin
      r_ar   <= a_re;
      r_ai   <= a_im;
      r_br   <= b_re;
      r_bim  <= w_bim;
      r_p_rr <= F'(r_ar) * F'(r_br);
      r_p_ib <= F'(r_ai) * F'(r_bim);
      r_p_rb <= F'(r_ar) * F'(r_bim);
      r_p_ir <= F'(r_ai) * F'(r_br);
    end
  end
  // valid bits and output register; reset drops all in-flight samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      out_valid <= 1'b0;
      c_re      <= '0;
      c_im      <= '0;
      ovf       <= 1'b0;
    end else if (w_ce) begin
      r_s1_v    <= in_valid;
      r_s2_v    <= r_s1_v;
      out_valid <= r_s2_v;
      c_re      <= w_c_re;
      c_im      <= w_c_im;
      ovf       <= r_s2_v && w_ovf;
    end
  end
endmodule

// File: tb/tb_complex_multiplier_stream.sv
// tb_complex_multiplier_stream: scoreboard bench driving a full-width and a 16-bit instance in lockstep
module tb_complex_multiplier_stream;
  localparam int AW = 10;
  localparam int BW = 15;
`ifdef CMPLX_MULT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    longint re;
    longint im;
    longint re16;
    longint im16;
    bit     ovf16;
  } exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_conj, out_ready;
  logic signed [AW-1:0] a_re, a_im;
  logic signed [BW-1:0] b_re, b_im;
  logic in_ready, in_ready16, out_valid, out_valid16, ovf, ovf16;
  logic signed [25:0] c_re, c_im;
  logic signed [15:0] c16_re, c16_im;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  complex_multiplier_stream #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(26), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_conj(in_conj),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_ready(out_ready), .c_re(c_re), .c_im(c_im), .ovf(ovf));

  complex_multiplier_stream #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(16), .SHIFT(0)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_conj(in_conj),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid16), .out_ready(out_ready), .c_re(c16_re), .c_im(c16_im), .ovf(ovf16));

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input longint re, input longint im, input longint re16, input longint im16, input bit o);
    exp_t e;
    e.re = re;
    e.im = im;
    e.re16 = re16;
    e.im16 = im16;
    e.ovf16 = o;
    return e;
  endfunction

  function automatic longint to16(input longint x);
    logic signed [15:0] t;
    if (SAT) return x > 32767 ? 32767 : (x < -32768 ? -32768 : x);
    t = x[15:0];
    return longint'(t);
  endfunction

  function automatic exp_t model(input longint ar, input longint ai, input longint br, input longint bi, input bit cj);
    longint bb, re, im;
    bb = cj ? -bi : bi;
    re = ar * br - ai * bb;
    im = ar * bb + ai * br;
    return mk(re, im, to16(re), to16(im), SAT && (to16(re) != re || to16(im) != im));
  endfunction

  // scoreboard monitor: pop on each output transfer, police stalls and idle ovf
  logic prev_stall = 1'b0;
  logic signed [25:0] pr, pi;
  always @(negedge clk) begin
    exp_t e;
    if (rst) prev_stall = 1'b0;
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got re=%0d im=%0d expected no output", c_re, c_im);
        end else begin
          e = q.pop_front();
          chk("c_re", c_re, e.re);
          chk("c_im", c_im, e.im);
          chk("ovf_full", ovf, 0);
          chk("valid16", out_valid16, 1);
          chk("c16_re", c16_re, e.re16);
          chk("c16_im", c16_im, e.im16);
          chk("ovf16", ovf16, e.ovf16);
        end
      end
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      if (prev_stall) begin
        chk("hold_re", c_re, pr);
        chk("hold_im", c_im, pi);
      end
      if (!out_valid16) chk("ovf16_idle", ovf16, 0);
      prev_stall = out_valid && !out_ready;
      pr = c_re;
      pi = c_im;
    end
  end

  task automatic send(input longint ar, input longint ai, input longint br, input longint bi, input bit cj, input exp_t e);
    a_re = ar[AW-1:0];
    a_im = ai[AW-1:0];
    b_re = br[BW-1:0];
    b_im = bi[BW-1:0];
    in_conj = cj;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (in_ready && in_ready16) begin
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout: got in_ready=0 expected 1");
    in_valid = 1'b0;
  endtask

  task automatic send_m(input longint ar, input longint ai, input longint br, input longint bi, input bit cj);
    send(ar, ai, br, bi, cj, model(ar, ai, br, bi, cj));
  endtask

  task automatic lat_check(input string name);
    @(negedge clk);
    chk({name, "_c1"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_c2"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_c3"}, out_valid, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask

  longint sv[10][5] = '{
    '{100, -200, 1234, -4321, 0},
    '{-512, 511, -16384, 16383, 1},
    '{7, 7, 7, 7, 0},
    '{0, 0, 0, 0, 1},
    '{-1, -1, -1, -1, 0},
    '{511, 511, 16383, 16383, 0},
    '{-300, 45, -9000, 12000, 1},
    '{1, 0, 0, 1, 0},
    '{0, 1, 0, 1, 1},
    '{-512, 0, -16384, 0, 1}
  };

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_conj = 1'b0;
    a_re = '0;
    a_im = '0;
    b_re = '0;
    b_im = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c_re", c_re, 0);
    chk("rst_c_im", c_im, 0);
    chk("rst_ovf16", ovf16, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", in_ready, 1);
    send(3, 4, 5, -2, 0, mk(23, 14, 23, 14, 0));
    lat_check("lat_t1");
    drain();
    send(3, 4, 5, -2, 1, mk(7, 26, 7, 26, 0));
    drain();
    send(-512, -512, -16384, -16384, 0, mk(0, 16777216, 0, SAT ? 32767 : 0, SAT));
    drain();
    fork
      for (int i = 0; i < 10; i++) send_m(sv[i][0], sv[i][1], sv[i][2], sv[i][3], sv[i][4] != 0);
      begin
        repeat (4) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    drain();
    send_m(10, 20, 30, 40, 0);
    send_m(-5, 6, -7, 8, 1);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_c_re", c_re, 0);
    chk("midrst_c_im", c_im, 0);
    send(3, 4, 5, -2, 0, mk(23, 14, 23, 14, 0));
    lat_check("lat_t6");
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
